// File: rtl/t64_mem_pkg.sv
// t64_mem_pkg: shared types and widths for the 64-bit memory port arbiter.
//   state_e : arbiter FSM states (IDLE, ISSUE, WAIT, RESP)
//   owner_e : which requester owns the outstanding access
//   T64_ADDR_W / T64_WORD_W : byte-address and data-word widths
package t64_mem_pkg;

    localparam int T64_ADDR_W = 32;
    localparam int T64_WORD_W = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundles the IF port, D port and memory-side bus of the arbiter.
//   IF port  : if_req_valid/addr in, if_req_ready, if_rsp_valid/data out
//   D port   : d_req_valid/write/addr/wdata in, d_req_ready, d_rsp_valid/data out
//   memory   : mem_addr, mem_write_data, mem_read_en, mem_write_en out, mem_read_data in
//   status   : busy out
//   slave modport = arbiter view, master modport = cpu/memory view.
interface mem_port_arbiter_if
    import t64_mem_pkg::*;
    ;
    logic                  if_req_valid;
    logic [T64_ADDR_W-1:0] if_req_addr;
    logic                  if_req_ready;
    logic                  if_rsp_valid;
    logic [T64_WORD_W-1:0] if_rsp_data;
    logic                  d_req_valid;
    logic                  d_req_write;
    logic [T64_ADDR_W-1:0] d_req_addr;
    logic [T64_WORD_W-1:0] d_req_wdata;
    logic                  d_req_ready;
    logic                  d_rsp_valid;
    logic [T64_WORD_W-1:0] d_rsp_data;
    logic [T64_ADDR_W-1:0] mem_addr;
    logic [T64_WORD_W-1:0] mem_write_data;
    logic                  mem_read_en;
    logic                  mem_write_en;
    logic [T64_WORD_W-1:0] mem_read_data;
    logic                  busy;

    modport slave (
        input  if_req_valid, if_req_addr,
        input  d_req_valid, d_req_write, d_req_addr, d_req_wdata,
        input  mem_read_data,
        output if_req_ready, if_rsp_valid, if_rsp_data,
        output d_req_ready, d_rsp_valid, d_rsp_data,
        output mem_addr, mem_write_data, mem_read_en, mem_write_en,
        output busy
    );

    modport master (
        output if_req_valid, if_req_addr,
        output d_req_valid, d_req_write, d_req_addr, d_req_wdata,
        output mem_read_data,
        input  if_req_ready, if_rsp_valid, if_rsp_data,
        input  d_req_ready, d_rsp_valid, d_rsp_data,
        input  mem_addr, mem_write_data, mem_read_en, mem_write_en,
        input  busy
    );

endinterface

// File: rtl/mem_port_arbiter_rr_arb2.sv
// rr_arb2: two-requester arbiter (IF vs D) with round-robin or D-priority plus IF starvation guard.
//   clk, reset_n : clock, asynchronous active-low reset
//   req_if/req_d : request valids
//   enable       : arbitration allowed this cycle (owner FSM idle)
//   accept       : the granted request is taken this cycle
//   grant        : one-hot grant, bit 0 = IF, bit 1 = D
module rr_arb2
    import t64_mem_pkg::*;
#(
    parameter int FIXED_PRIO   = 0,
    parameter int STARVE_LIMIT = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req_if,
    input  logic       req_d,
    input  logic       enable,
    input  logic       accept,
    output logic [1:0] grant
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    owner_e     last_grant_q, last_grant_d;
    logic [3:0] starve_cnt_q, starve_cnt_d;
    logic       if_wins;

    always_comb begin
        // A tie goes to IF when round-robin says it's IF's turn, or when D-priority has starved IF long enough.
        if_wins      = req_if && (!req_d || (FIXED_PRIO != 0 ? starve_cnt_q == LIMIT : last_grant_q == OWN_D));
        grant        = enable ? {req_d && !if_wins, if_wins} : 2'b00;
        last_grant_d = last_grant_q;
        starve_cnt_d = starve_cnt_q;
        if (accept) begin
            last_grant_d = grant[0] ? OWN_IF : OWN_D;
            starve_cnt_d = (req_if && !grant[0]) ? (starve_cnt_q == LIMIT ? LIMIT : starve_cnt_q + 4'd1) : 4'd0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q <= OWN_D;
            starve_cnt_q <= 4'd0;
        end else begin
            last_grant_q <= last_grant_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported 64-bit memory between the IF and D requesters, one access at a time.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : slave view of mem_port_arbiter_if (both request/response ports, memory bus, busy)
//   Access flow IDLE -> ISSUE -> WAIT (reads only, MEM_LAT cycles) -> RESP -> IDLE.
module mem_port_arbiter
    import t64_mem_pkg::*;
#(
    parameter int MEM_LAT      = 1,
    parameter int FIXED_PRIO   = 0,
    parameter int STARVE_LIMIT = 4
) (
    input logic                clk,
    input logic                reset_n,
    mem_port_arbiter_if.slave  bus
);

    state_e                state_q, state_d;
    owner_e                owner_q, owner_d;
    logic                  write_q, write_d;
    logic [2:0]            lat_cnt_q, lat_cnt_d;
    logic [T64_ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [T64_WORD_W-1:0] mem_write_data_q, mem_write_data_d;
    logic                  mem_read_en_q, mem_read_en_d;
    logic                  mem_write_en_q, mem_write_en_d;
    logic [T64_WORD_W-1:0] if_rsp_data_q, if_rsp_data_d;
    logic [T64_WORD_W-1:0] d_rsp_data_q, d_rsp_data_d;
    logic                  if_rsp_valid_q, if_rsp_valid_d;
    logic                  d_rsp_valid_q, d_rsp_valid_d;
    logic [1:0]            grant;
    logic                  accept;

    rr_arb2 #(
        .FIXED_PRIO  (FIXED_PRIO),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_arb (
        .clk    (clk),
        .reset_n(reset_n),
        .req_if (bus.if_req_valid),
        .req_d  (bus.d_req_valid),
        .enable (state_q == IDLE),
        .accept (accept),
        .grant  (grant)
    );

    assign accept = (bus.if_req_valid && grant[0]) || (bus.d_req_valid && grant[1]);

    always_comb begin
        state_d          = state_q;
        owner_d          = owner_q;
        write_d          = write_q;
        lat_cnt_d        = lat_cnt_q;
        mem_addr_d       = mem_addr_q;
        mem_write_data_d = mem_write_data_q;
        mem_read_en_d    = 1'b0;
        mem_write_en_d   = 1'b0;
        if_rsp_data_d    = if_rsp_data_q;
        d_rsp_data_d     = d_rsp_data_q;
        unique case (state_q)
            IDLE: if (accept) begin
                // Controls are loaded on the accept edge so they are already registered during ISSUE.
                owner_d        = grant[0] ? OWN_IF : OWN_D;
                write_d        = grant[1] && bus.d_req_write;
                mem_addr_d     = grant[0] ? bus.if_req_addr : bus.d_req_addr;
                mem_write_data_d = write_d ? bus.d_req_wdata : mem_write_data_q;
                mem_read_en_d  = !write_d;
                mem_write_en_d = write_d;
                state_d        = ISSUE;
            end
            ISSUE: begin
                lat_cnt_d    = 3'(MEM_LAT - 1);
                d_rsp_data_d = write_q ? '0 : d_rsp_data_q;
                state_d      = write_q ? RESP : WAIT;
            end
            WAIT: if (lat_cnt_q == 3'd0) begin
                if_rsp_data_d = owner_q == OWN_IF ? bus.mem_read_data : if_rsp_data_q;
                d_rsp_data_d  = owner_q == OWN_D ? bus.mem_read_data : d_rsp_data_q;
                state_d       = RESP;
            end else begin
                lat_cnt_d = lat_cnt_q - 3'd1;
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // RESP lasts one cycle, so entering it yields a single-cycle registered pulse.
        if_rsp_valid_d = state_d == RESP && owner_q == OWN_IF;
        d_rsp_valid_d  = state_d == RESP && owner_q == OWN_D;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= IDLE;
            owner_q          <= OWN_IF;
            write_q          <= 1'b0;
            lat_cnt_q        <= 3'd0;
            mem_addr_q       <= '0;
            mem_write_data_q <= '0;
            mem_read_en_q    <= 1'b0;
            mem_write_en_q   <= 1'b0;
            if_rsp_data_q    <= '0;
            d_rsp_data_q     <= '0;
            if_rsp_valid_q   <= 1'b0;
            d_rsp_valid_q    <= 1'b0;
        end else begin
            state_q          <= state_d;
            owner_q          <= owner_d;
            write_q          <= write_d;
            lat_cnt_q        <= lat_cnt_d;
            mem_addr_q       <= mem_addr_d;
            mem_write_data_q <= mem_write_data_d;
            mem_read_en_q    <= mem_read_en_d;
            mem_write_en_q   <= mem_write_en_d;
            if_rsp_data_q    <= if_rsp_data_d;
            d_rsp_data_q     <= d_rsp_data_d;
            if_rsp_valid_q   <= if_rsp_valid_d;
            d_rsp_valid_q    <= d_rsp_valid_d;
        end
    end

    assign bus.if_req_ready   = grant[0];
    assign bus.d_req_ready    = grant[1];
    assign bus.if_rsp_valid   = if_rsp_valid_q;
    assign bus.if_rsp_data    = if_rsp_data_q;
    assign bus.d_rsp_valid    = d_rsp_valid_q;
    assign bus.d_rsp_data     = d_rsp_data_q;
    assign bus.mem_addr       = mem_addr_q;
    assign bus.mem_write_data = mem_write_data_q;
    assign bus.mem_read_en    = mem_read_en_q;
    assign bus.mem_write_en   = mem_write_en_q;
    assign bus.busy           = state_q != IDLE;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: drives three arbiter configurations with shared stimulus, each with its own latency memory model.
//   u0: MEM_LAT=1 round-robin, u1: MEM_LAT=1 D-priority (STARVE_LIMIT=4), u2: MEM_LAT=3 round-robin.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        if_valid = 1'b0;
    logic [31:0] if_addr = '0;
    logic        d_valid = 1'b0;
    logic        d_write = 1'b0;
    logic [31:0] d_addr = '0;
    logic [63:0] d_wdata = '0;

    logic        if_rdy [3];
    logic        d_rdy [3];
    logic        if_rv [3];
    logic        d_rv [3];
    logic [63:0] ifd [3];
    logic [63:0] dd [3];
    logic [31:0] maddr [3];
    logic [63:0] mwd [3];
    logic        mre [3];
    logic        mwe [3];
    logic        busy [3];
    logic [3:0]  starve [3];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int ML = g == 2 ? 3 : 1;
        mem_port_arbiter_if bus ();
        logic [63:0] mem [16];
        logic [3:0]  ra = '0;
        int          cnt = 0;

        mem_port_arbiter #(
            .MEM_LAT     (ML),
            .FIXED_PRIO  (g == 1 ? 1 : 0),
            .STARVE_LIMIT(4)
        ) u_dut (
            .clk    (clk),
            .reset_n(reset_n),
            .bus    (bus.slave)
        );

        initial begin
            for (int i = 0; i < 16; i++) mem[i] = {32'hC0DE0000 | 32'(i), 32'(i)};
            mem[4] = 64'hDEADBEEF_00000001;
        end

        always @(posedge clk) begin
            if (bus.mem_write_en) mem[bus.mem_addr[6:3]] <= bus.mem_write_data;
            if (bus.mem_read_en) begin
                ra  <= bus.mem_addr[6:3];
                cnt <= ML;
            end else if (cnt > 0) begin
                cnt <= cnt - 1;
            end
        end

        assign bus.if_req_valid  = if_valid;
        assign bus.if_req_addr   = if_addr;
        assign bus.d_req_valid   = d_valid;
        assign bus.d_req_write   = d_write;
        assign bus.d_req_addr    = d_addr;
        assign bus.d_req_wdata   = d_wdata;
        assign bus.mem_read_data = cnt == 1 ? mem[ra] : 64'hBAD;

        assign if_rdy[g] = bus.if_req_ready;
        assign d_rdy[g]  = bus.d_req_ready;
        assign if_rv[g]  = bus.if_rsp_valid;
        assign d_rv[g]   = bus.d_rsp_valid;
        assign ifd[g]    = bus.if_rsp_data;
        assign dd[g]     = bus.d_rsp_data;
        assign maddr[g]  = bus.mem_addr;
        assign mwd[g]    = bus.mem_write_data;
        assign mre[g]    = bus.mem_read_en;
        assign mwe[g]    = bus.mem_write_en;
        assign busy[g]   = bus.busy;
        assign starve[g] = u_dut.u_arb.starve_cnt_q;
    end

    typedef struct {
        logic        is_d;
        logic        wr;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] outs_of(input int k);
        return {63'(maddr[k] | mwd[k][31:0] | mwd[k][63:32] | ifd[k][31:0] | ifd[k][63:32] | dd[k][31:0] | dd[k][63:32]),
                if_rv[k] | d_rv[k] | mre[k] | mwe[k] | busy[k]};
    endfunction

    task automatic xact(input int idx, input vec_t v);
        int          cyc [3];
        int          npl [3];
        int          wrong;
        logic [63:0] dat [3];
        wrong = 0;
        for (int k = 0; k < 3; k++) begin
            cyc[k] = -1;
            npl[k] = 0;
            dat[k] = '0;
        end
        @(negedge clk);
        if_valid = !v.is_d;
        if_addr  = v.addr;
        d_valid  = v.is_d;
        d_write  = v.wr;
        d_addr   = v.addr;
        d_wdata  = v.wdata;
        #1;
        chk($sformatf("v%0d_ready", idx), 64'({if_rdy[0], d_rdy[0]}), v.is_d ? 64'd1 : 64'd2);
        @(posedge clk);
        #1;
        if_valid = 1'b0;
        d_valid  = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 0) begin
                chk($sformatf("v%0d_read_en", idx), 64'(mre[0]), 64'(!v.wr));
                chk($sformatf("v%0d_write_en", idx), 64'(mwe[0]), 64'(v.wr));
                chk($sformatf("v%0d_mem_addr", idx), 64'(maddr[0]), 64'(v.addr));
                if (v.wr) chk($sformatf("v%0d_mem_wdata", idx), mwd[0], v.wdata);
            end
            for (int k = 0; k < 3; k += 2) begin
                if (v.is_d ? d_rv[k] : if_rv[k]) begin
                    npl[k]++;
                    cyc[k] = c;
                    dat[k] = v.is_d ? dd[k] : ifd[k];
                end
                if (v.is_d ? if_rv[k] : d_rv[k]) wrong++;
            end
        end
        chk($sformatf("v%0d_u0_pulses", idx), 64'(npl[0]), 64'd1);
        chk($sformatf("v%0d_u0_rsp_cycle", idx), 64'(cyc[0]), v.wr ? 64'd1 : 64'd2);
        chk($sformatf("v%0d_u0_rsp_data", idx), dat[0], v.exp);
        chk($sformatf("v%0d_u0_data_hold", idx), v.is_d ? dd[0] : ifd[0], v.exp);
        chk($sformatf("v%0d_u2_pulses", idx), 64'(npl[2]), 64'd1);
        chk($sformatf("v%0d_u2_rsp_cycle", idx), 64'(cyc[2]), v.wr ? 64'd1 : 64'd4);
        chk($sformatf("v%0d_u2_rsp_data", idx), dat[2], v.exp);
        chk($sformatf("v%0d_wrong_port", idx), 64'(wrong), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [1:0] g0 [$];
        logic [1:0] g1 [$];
        logic [1:0] exp0 [4];
        logic [1:0] exp1 [6];
        logic [3:0] st_at_if;
        int         both;
        int         pulses;

        vecs[0] = '{1'b0, 1'b0, 32'h20, 64'h0, 64'hDEADBEEF_00000001};
        vecs[1] = '{1'b1, 1'b1, 32'h08, 64'h0123456789ABCDEF, 64'h0};
        vecs[2] = '{1'b1, 1'b0, 32'h08, 64'h0, 64'h0123456789ABCDEF};
        vecs[3] = '{1'b0, 1'b0, 32'h0C, 64'h0, 64'h0123456789ABCDEF};
        vecs[4] = '{1'b1, 1'b1, 32'h78, 64'hFFFFFFFF_FFFFFFFF, 64'h0};
        vecs[5] = '{1'b0, 1'b0, 32'h7F, 64'h0, 64'hFFFFFFFF_FFFFFFFF};
        vecs[6] = '{1'b1, 1'b0, 32'h30, 64'h0, 64'hC0DE0006_00000006};
        exp0 = '{2'd0, 2'd1, 2'd0, 2'd1};
        exp1 = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd1};

        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) chk($sformatf("reset_outs_u%0d", k), outs_of(k), 64'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 7; i++) xact(i, vecs[i]);

        do_reset();
        if_valid = 1'b1;
        if_addr  = 32'h20;
        d_valid  = 1'b1;
        d_write  = 1'b0;
        d_addr   = 32'h30;
        both     = 0;
        st_at_if = 4'hF;
        for (int c = 0; c < 80 && (g0.size() < 4 || g1.size() < 6); c++) begin
            #1;
            for (int k = 0; k < 2; k++) begin
                if (if_rdy[k] && d_rdy[k]) both++;
                if (k == 0 && if_rdy[0]) g0.push_back(2'd0);
                if (k == 0 && d_rdy[0]) g0.push_back(2'd1);
                if (k == 1 && if_rdy[1]) begin
                    g1.push_back(2'd0);
                    if (st_at_if == 4'hF) st_at_if = starve[1];
                end
                if (k == 1 && d_rdy[1]) g1.push_back(2'd1);
            end
            @(negedge clk);
        end
        if_valid = 1'b0;
        d_valid  = 1'b0;
        for (int i = 0; i < 4; i++) chk($sformatf("rr_grant%0d", i), i < g0.size() ? 64'(g0[i]) : 64'd3, 64'(exp0[i]));
        for (int i = 0; i < 6; i++) chk($sformatf("prio_grant%0d", i), i < g1.size() ? 64'(g1[i]) : 64'd3, 64'(exp1[i]));
        chk("starve_at_if_grant", 64'(st_at_if), 64'd4);
        chk("ready_both_high", 64'(both), 64'd0);
        repeat (10) @(negedge clk);

        do_reset();
        @(negedge clk);
        if_valid = 1'b1;
        if_addr  = 32'h20;
        @(posedge clk);
        #1;
        if_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("busy_in_wait", 64'(busy[0]), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("async_reset_u0", outs_of(0), 64'd0);
        chk("async_reset_u2", outs_of(2), 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) pulses += int'(if_rv[k]) + int'(d_rv[k]);
        end
        chk("no_rsp_after_reset", 64'(pulses), 64'd0);
        xact(7, vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
